// File: rtl/i2s_sample_tx_pkg.sv
// Shared definitions for the I2S sample transmitter: default geometry,
// channel encoding and a counter-width helper.
package i2s_sample_tx_pkg;

  // Default frame geometry, kept next to the other fixed-point sample defaults.
  localparam int I2S_WIDTH_DEF     = 24;
  localparam int I2S_SLOT_BITS_DEF = 32;
  localparam int I2S_BCLK_DIV_DEF  = 4;

  // Word-select encoding as driven on LRCLK.
  typedef enum logic {
    I2S_LEFT  = 1'b0,
    I2S_RIGHT = 1'b1
  } i2s_chan_t;

  // Width of a counter covering 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// BCLK generator: divides clk by 2*BCLK_DIV and flags the cycle in which
// BCLK falls, so the transmitter can update its outputs in step with it.
module i2s_clk_div
  import i2s_sample_tx_pkg::*;
#(
  parameter int BCLK_DIV = I2S_BCLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic bclk_o,
  output logic fall_event_o
);

  localparam int            CW       = cnt_width(BCLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BCLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          term;

  // Half-period counter; BCLK toggles each time it wraps.
  always_comb begin
    term      = (div_cnt_q == CNT_LAST);
    div_cnt_d = term ? '0 : div_cnt_q + CW'(1);
    bclk_d    = term ? ~bclk_q : bclk_q;
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  assign bclk_o       = bclk_q;
  // High in the cycle whose closing edge takes BCLK from 1 to 0.
  assign fall_event_o = term & bclk_q;

endmodule

// File: rtl/i2s_sample_tx.sv
// I2S transmitter: each mono sample is sent MSB first on both the left and
// right slots of a frame, with the standard one-BCLK delay after LRCLK.
// A one-entry holding buffer with a valid/ready handshake sits in front.
// Optional: define I2S_UNDERRUN_COUNT_EN to add the underrun_cnt output.
//
// Handshake: a sample transfers in any clk cycle where in_valid && in_ready.
// in_ready depends only on registers (buffer empty), never on in_valid; the
// producer holds in_valid and in_sample stable until the transfer happens.
module i2s_sample_tx
  import i2s_sample_tx_pkg::*;
#(
  parameter int WIDTH     = I2S_WIDTH_DEF,
  parameter int SLOT_BITS = I2S_SLOT_BITS_DEF,
  parameter int BCLK_DIV  = I2S_BCLK_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_sample,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata
`ifdef I2S_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);

  localparam int            FRAME    = 2 * SLOT_BITS;
  localparam int            SW       = cnt_width(FRAME);
  localparam logic [SW-1:0] S_LAST   = SW'(FRAME - 1);
  localparam logic [SW-1:0] S_RESET  = SW'(FRAME - 2);
  localparam logic [SW-1:0] S_RIGHT0 = SW'(SLOT_BITS);
  localparam logic [SW-1:0] S_LR_HI  = SW'(SLOT_BITS - 1);
  localparam logic [SW-1:0] S_WIDTH  = SW'(WIDTH);

  logic             fall_event;
  logic [SW-1:0]    s_q, s_d;          // slot index within the frame
  i2s_chan_t        chan_q, chan_d;    // registered word select
  logic             sdata_q, sdata_d;
  logic [WIDTH-1:0] sh_q, sh_d;        // bits still to send in this slot
  logic [WIDTH-1:0] frame_q, frame_d;  // word of the current frame (hold value)
  logic [WIDTH-1:0] buf_q, buf_d;      // holding buffer
  logic             full_q, full_d;
  logic             take, load;
  logic             in_left, in_right;

  i2s_clk_div #(
    .BCLK_DIV(BCLK_DIV)
  ) u_clk_div (
    .clk         (clk),
    .rst         (rst),
    .bclk_o      (bclk),
    .fall_event_o(fall_event)
  );

  // Slot advance, LRCLK/SDATA generation, frame load and buffer update.
  always_comb begin
    s_d      = s_q;
    chan_d   = chan_q;
    sdata_d  = sdata_q;
    sh_d     = sh_q;
    frame_d  = frame_q;
    buf_d    = buf_q;
    full_d   = full_q;
    load     = 1'b0;
    in_left  = 1'b0;
    in_right = 1'b0;
    take     = in_valid && !full_q;
    if (fall_event) begin
      s_d      = (s_q == S_LAST) ? '0 : s_q + SW'(1);
      load     = (s_d == S_LAST);
      // LRCLK leads the data by one BCLK: it switches one slot early.
      chan_d   = (s_d >= S_LR_HI && s_d != S_LAST) ? I2S_RIGHT : I2S_LEFT;
      in_left  = (s_d < S_WIDTH);
      in_right = (s_d >= S_RIGHT0) && ((s_d - S_RIGHT0) < S_WIDTH);
      if (s_d == '0 || s_d == S_RIGHT0) begin
        sdata_d = frame_q[WIDTH-1];
        sh_d    = frame_q << 1;
      end else if (in_left || in_right) begin
        sdata_d = sh_q[WIDTH-1];
        sh_d    = sh_q << 1;
      end else begin
        sdata_d = 1'b0;
      end
    end
    // On underrun the previous word is repeated rather than sending silence.
    if (load) begin
      frame_d = full_q ? buf_q : frame_q;
      full_d  = 1'b0;
    end
    // A transfer in the load cycle refills the buffer after it was read.
    if (take) begin
      buf_d  = in_sample;
      full_d = 1'b1;
    end
  end

  // Transmitter state registers; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= S_RESET;
      chan_q  <= I2S_RIGHT;
      sdata_q <= 1'b0;
      sh_q    <= '0;
      frame_q <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      s_q     <= s_d;
      chan_q  <= chan_d;
      sdata_q <= sdata_d;
      sh_q    <= sh_d;
      frame_q <= frame_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
    end
  end

`ifdef I2S_UNDERRUN_COUNT_EN
  logic [15:0] under_q;

  // Saturating count of frame loads that found the buffer empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      under_q <= '0;
    end else if (load && !full_q && under_q != 16'hFFFF) begin
      under_q <= under_q + 16'd1;
    end
  end

  assign underrun_cnt = under_q;
`endif

  assign in_ready = ~full_q;
  assign lrclk    = chan_q;
  assign sdata    = sdata_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
`timescale 1ns/1ps
module tb_i2s_sample_tx;

  localparam int W         = 24;
  localparam int SB        = 32;
  localparam int DIV       = 2;
  localparam int BIT_CYC   = 2 * DIV;            // clk cycles per BCLK period
  localparam int FRAME_CYC = 2 * SB * BIT_CYC;   // clk cycles per frame
  localparam int LOAD_PH   = BIT_CYC;            // cycle (mod frame) of each load

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] in_sample;
  logic         in_valid;
  logic         in_ready, bclk, lrclk, sdata;
`ifdef I2S_UNDERRUN_COUNT_EN
  logic [15:0]  underrun_cnt;
`endif

  i2s_sample_tx #(
    .WIDTH    (W),
    .SLOT_BITS(SB),
    .BCLK_DIV (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_sample(in_sample),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata)
`ifdef I2S_UNDERRUN_COUNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  // ---------------- check bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: a load happens every FRAME_CYC cycles, the first one
  // LOAD_PH cycles after reset release. Each load emits the word the next
  // frame must carry.
  logic [W-1:0] exp_q[$];
  int           cyc = 0;
  logic         m_full;
  logic [W-1:0] m_buf, m_last;
  int           m_under;
  int           n_pushed = 0, n_flushed = 0, n_popped = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_full = 1'b0; m_buf = '0; m_last = '0; m_under = 0;
      n_flushed += exp_q.size();
      exp_q.delete();
    end else begin
      logic take;
      cyc++;
      take = in_valid && !m_full;
      if (cyc % FRAME_CYC == LOAD_PH) begin
        if (m_full) m_last = m_buf;
        else if (m_under < 65535) m_under++;
        exp_q.push_back(m_last);
        n_pushed++;
        m_full = 1'b0;
      end
      if (take) begin
        m_buf  = in_sample;
        m_full = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  // Decodes the serial stream at BCLK rising edges (observed on clk
  // falling edges) and compares each finished frame with the queue head.
  logic         bclk_prev, lr_prev, synced, bad_pad, bad_per;
  int           s_mon, last_rise;
  logic [W-1:0] l_word, r_word;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      bclk_prev = 1'b0; lr_prev = 1'b1; synced = 1'b0; s_mon = 2*SB-2;
      bad_pad = 1'b0; bad_per = 1'b0; last_rise = -1; l_word = '0; r_word = '0;
    end else begin
      check("in_ready", in_ready, !m_full);
      if (bclk && !bclk_prev) begin
        if (!lrclk && lr_prev) begin
          if (synced && s_mon != 2*SB-2) check("frame_length", s_mon, 2*SB-2);
          synced = 1'b1; s_mon = 2*SB-1;
          bad_pad = 1'b0; bad_per = 1'b0; l_word = '0; r_word = '0;
        end else begin
          s_mon = (s_mon + 1) % (2*SB);
        end
        if (last_rise >= 0 && cyc - last_rise != BIT_CYC) bad_per = 1'b1;
        last_rise = cyc;
        if (synced) begin
          if (lrclk !== ((s_mon >= SB-1) && (s_mon <= 2*SB-2))) bad_pad = 1'b1;
          if (s_mon < W) l_word = {l_word[W-2:0], sdata};
          else if (s_mon >= SB && s_mon < SB+W) r_word = {r_word[W-2:0], sdata};
          else if (sdata !== 1'b0) bad_pad = 1'b1;
          if (s_mon == 2*SB-2) begin
            if (exp_q.size() == 0) begin
              check("frame_unexpected", 1, 0);
            end else begin
              logic [W-1:0] e;
              e = exp_q.pop_front();
              n_popped++;
              check("left_word", l_word, e);
              check("right_word", r_word, e);
              check("pad_and_lrclk", bad_pad, 0);
              check("bclk_period", bad_per, 0);
            end
          end
        end
        lr_prev = lrclk;
      end
      bclk_prev = bclk;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [W-1:0] d);
    int n = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_sample = d;
    while (!in_ready && n < 4*FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Advance to the next falling clk edge at which cyc mod frame equals ph.
  task automatic wait_phase(input int ph);
    int n = 0;
    @(negedge clk);
    while ((cyc % FRAME_CYC) != ph && n < 2*FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    if ((cyc % FRAME_CYC) != ph) check("wait_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
`ifdef I2S_UNDERRUN_COUNT_EN
    logic [15:0] u0;
`endif
    in_valid = 1'b0; in_sample = '0; rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_bclk", bclk, 0);
    check("rst_lrclk", lrclk, 1);
    check("rst_sdata", sdata, 0);
    rst = 1'b0;

    // Idle start-up: BCLK rises at cycle 2, first fall at cycle 4.
    @(negedge clk); check("bclk_c1", bclk, 0);
    @(negedge clk); check("bclk_c2", bclk, 1);
    @(negedge clk); check("lrclk_c3", lrclk, 1);
    @(negedge clk); check("bclk_c4", bclk, 0);
    check("lrclk_first_fall", lrclk, 0);

    // Single sample: buffer fills, empties on the next load.
    wait_phase(100);
    push(24'h800001);
    check("ready_when_full", in_ready, 0);
    wait_phase(LOAD_PH);
    check("ready_after_load", in_ready, 1);

    // Back-pressure: second sample stalls until the following load.
    push(24'hABCDEF);
    push(24'h123456);
    check("stall_release_phase", cyc % FRAME_CYC, LOAD_PH + 1);

    // Underrun: the last word repeats for two frames.
    push(24'h7FFFFF);
    wait_phase(LOAD_PH);
`ifdef I2S_UNDERRUN_COUNT_EN
    u0 = underrun_cnt;
`endif
    wait_phase(LOAD_PH);
    wait_phase(LOAD_PH);
`ifdef I2S_UNDERRUN_COUNT_EN
    check("underrun_delta", underrun_cnt - u0, 2);
    check("underrun_cnt", underrun_cnt, m_under);
`endif

    // Asynchronous reset in the middle of a frame carrying FFFFFF.
    push(24'hFFFFFF);
    wait_phase(LOAD_PH);
    wait_phase(LOAD_PH + 11*BIT_CYC);
    check("pre_reset_sdata", sdata, 1);
    check("pre_reset_lrclk", lrclk, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_bclk", bclk, 0);
    check("async_rst_lrclk", lrclk, 1);
    check("async_rst_sdata", sdata, 0);
    check("async_rst_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Offer a sample exactly in the first load cycle after reset.
    wait_phase(LOAD_PH - 1);
    check("load_cycle_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_sample = W'($urandom);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("ready_drop_after_load", in_ready, 0);

    // Random samples with random gaps.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 400)) @(negedge clk);
      push(W'($urandom));
    end

    // Let the last sample go out, then require an empty scoreboard.
    n = 0;
    while (m_full && n < 2*FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    wait_phase(LOAD_PH - 1);
    check("queue_drained", exp_q.size(), 0);
    check("frames_seen", n_popped, n_pushed - n_flushed);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
